// File: rtl/fft_pkg.sv
// Shared constants, types and FSM encoding for the 8-point FFT stream controller.
package fft_pkg;

    localparam int unsigned CW      = 32;  // complex word {re, im}
    localparam int unsigned HW      = 16;  // one Q4.11 component
    localparam int unsigned N       = 8;   // FFT size
    localparam int unsigned LOG2N   = 3;
    localparam int unsigned LAT_DEF = 2;   // fft008 register stages

    // Twiddles W^0..W^3, {re, im} in Q4.11
    localparam logic [CW-1:0] TW0 = 32'h0800_0000;
    localparam logic [CW-1:0] TW1 = 32'h05A8_FA58;
    localparam logic [CW-1:0] TW2 = 32'h0000_F801;
    localparam logic [CW-1:0] TW3 = 32'hFA58_FA58;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } in_state_e;

    typedef logic [N-1:0][CW-1:0] frame_t;

endpackage

// File: rtl/frame_buf8.sv
// 8 x 32 register file: single indexed write or full-frame parallel load, all entries readable.
module frame_buf8 import fft_pkg::*; (
    input  logic             ck_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [LOG2N-1:0] wr_idx_i,
    input  logic [CW-1:0]    wr_data_i,
    input  logic             ld_en_i,
    input  frame_t           ld_data_i,
    output frame_t           rd_data_o
);

    frame_t mem_q;
    frame_t mem_d;

    // Parallel load wins over an indexed write
    always_comb begin
        mem_d = mem_q;
        if (ld_en_i) begin
            mem_d = ld_data_i;
        end else if (wr_en_i) begin
            mem_d[wr_idx_i] = wr_data_i;
        end
    end

    // Storage with synchronous clear
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q;

endmodule

// File: rtl/fft8_stream_ctrl.sv
// Streaming controller around the fft008 datapath: fills an input frame, waits out the
// datapath latency, captures all bins at once and streams them out in bin order.
module fft8_stream_ctrl import fft_pkg::*; #(
    parameter int unsigned LAT = LAT_DEF,
    parameter logic [31:0] W0  = TW0,
    parameter logic [31:0] W1  = TW1,
    parameter logic [31:0] W2  = TW2,
    parameter logic [31:0] W3  = TW3
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    m_data,
    output logic [LOG2N-1:0] m_idx,
    output logic             m_last,
    output logic [CW-1:0]    xi_000,
    output logic [CW-1:0]    xi_001,
    output logic [CW-1:0]    xi_002,
    output logic [CW-1:0]    xi_003,
    output logic [CW-1:0]    xi_004,
    output logic [CW-1:0]    xi_005,
    output logic [CW-1:0]    xi_006,
    output logic [CW-1:0]    xi_007,
    output logic [CW-1:0]    Wi000,
    output logic [CW-1:0]    Wi001,
    output logic [CW-1:0]    Wi002,
    output logic [CW-1:0]    Wi003,
    input  logic [CW-1:0]    fo_000,
    input  logic [CW-1:0]    fo_001,
    input  logic [CW-1:0]    fo_002,
    input  logic [CW-1:0]    fo_003,
    input  logic [CW-1:0]    fo_004,
    input  logic [CW-1:0]    fo_005,
    input  logic [CW-1:0]    fo_006,
    input  logic [CW-1:0]    fo_007,
    output logic [15:0]      frames
);

    localparam int unsigned RW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    in_state_e        state_q, state_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             ovalid_q, ovalid_d;
    logic [LOG2N-1:0] ridx_q, ridx_d;
    logic [15:0]      frames_q, frames_d;

    logic   s_fire_c;
    logic   m_fire_c;
    logic   cap_c;
    frame_t ibuf_rd;
    frame_t obuf_rd;
    frame_t fo_frame;

    assign fo_frame = {fo_007, fo_006, fo_005, fo_004, fo_003, fo_002, fo_001, fo_000};

    // Input FSM, capture decision and output drain bookkeeping
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        ovalid_d = ovalid_q;
        ridx_d   = ridx_q;
        frames_d = frames_q;

        s_fire_c = (state_q == FILL) && s_valid;
        m_fire_c = ovalid_q && m_ready;
        // Capture into an empty output buffer, or into one whose last bin leaves this cycle
        cap_c    = (state_q == STALL) && (!ovalid_q || (m_fire_c && (ridx_q == LAST_IDX)));

        case (state_q)
            FILL: begin
                if (s_fire_c) begin
                    wcnt_d = wcnt_q + LOG2N'(1);
                    if (wcnt_q == LAST_IDX) begin
                        state_d = RUN;
                        rcnt_d  = '0;
                        wcnt_d  = '0;
                    end
                end
            end
            RUN: begin
                // STALL is entered as rcnt reaches LAT, so fo_* are sampled LAT+1 edges after the last write
                if (rcnt_q == RW'(LAT - 1)) begin
                    state_d = STALL;
                    rcnt_d  = RW'(LAT);
                end else begin
                    rcnt_d  = rcnt_q + RW'(1);
                end
            end
            STALL: begin
                if (cap_c) begin
                    state_d  = FILL;
                    frames_d = frames_q + 16'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (m_fire_c) begin
            ridx_d = ridx_q + LOG2N'(1);
            if (ridx_q == LAST_IDX) begin
                ovalid_d = 1'b0;
            end
        end
        if (cap_c) begin
            ovalid_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= FILL;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            ovalid_q <= 1'b0;
            ridx_q   <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            ovalid_q <= ovalid_d;
            ridx_q   <= ridx_d;
            frames_q <= frames_d;
        end
    end

    frame_buf8 ibuf (
        .ck_i      (ck),
        .rst_i     (rst),
        .wr_en_i   (s_fire_c),
        .wr_idx_i  (wcnt_q),
        .wr_data_i (s_data),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_data_o (ibuf_rd)
    );

    frame_buf8 obuf (
        .ck_i      (ck),
        .rst_i     (rst),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0),
        .ld_en_i   (cap_c),
        .ld_data_i (fo_frame),
        .rd_data_o (obuf_rd)
    );

    assign s_ready = (state_q == FILL);
    assign m_valid = ovalid_q;
    assign m_data  = obuf_rd[ridx_q];
    assign m_idx   = ridx_q;
    assign m_last  = (ridx_q == LAST_IDX);

    assign xi_000 = ibuf_rd[0];
    assign xi_001 = ibuf_rd[1];
    assign xi_002 = ibuf_rd[2];
    assign xi_003 = ibuf_rd[3];
    assign xi_004 = ibuf_rd[4];
    assign xi_005 = ibuf_rd[5];
    assign xi_006 = ibuf_rd[6];
    assign xi_007 = ibuf_rd[7];

    assign Wi000 = W0;
    assign Wi001 = W1;
    assign Wi002 = W2;
    assign Wi003 = W3;

    assign frames = frames_q;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Directed bench for fft8_stream_ctrl with a behavioural two-stage 8-point DFT standing in for fft008.
module tb_fft8_stream_ctrl;

    typedef logic [31:0] tb_frame_t [8];

    logic        ck = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_idx;
    logic        m_last;
    logic [31:0] xi_000, xi_001, xi_002, xi_003, xi_004, xi_005, xi_006, xi_007;
    logic [31:0] Wi000, Wi001, Wi002, Wi003;
    logic [15:0] frames;

    tb_frame_t   xin;
    tb_frame_t   xr_q;
    tb_frame_t   fo_q;
    logic [31:0] wi_arr [4];
    logic [31:0] ref_w  [4] = '{32'h0800_0000, 32'h05A8_FA58, 32'h0000_F801, 32'hFA58_FA58};

    int checks = 0;
    int errors = 0;

    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    tb_frame_t   cur;
    int          cur_n   = 0;
    int          exp_idx = 0;
    int          hs_cnt  = 0;

    always #5 ck = ~ck;

    fft8_stream_ctrl dut (
        .ck      (ck),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_last  (m_last),
        .xi_000  (xi_000),
        .xi_001  (xi_001),
        .xi_002  (xi_002),
        .xi_003  (xi_003),
        .xi_004  (xi_004),
        .xi_005  (xi_005),
        .xi_006  (xi_006),
        .xi_007  (xi_007),
        .Wi000   (Wi000),
        .Wi001   (Wi001),
        .Wi002   (Wi002),
        .Wi003   (Wi003),
        .fo_000  (fo_q[0]),
        .fo_001  (fo_q[1]),
        .fo_002  (fo_q[2]),
        .fo_003  (fo_q[3]),
        .fo_004  (fo_q[4]),
        .fo_005  (fo_q[5]),
        .fo_006  (fo_q[6]),
        .fo_007  (fo_q[7]),
        .frames  (frames)
    );

    assign xin[0] = xi_000;
    assign xin[1] = xi_001;
    assign xin[2] = xi_002;
    assign xin[3] = xi_003;
    assign xin[4] = xi_004;
    assign xin[5] = xi_005;
    assign xin[6] = xi_006;
    assign xin[7] = xi_007;
    assign wi_arr[0] = Wi000;
    assign wi_arr[1] = Wi001;
    assign wi_arr[2] = Wi002;
    assign wi_arr[3] = Wi003;

    // One DFT bin in Q4.11, products truncated by >>>11, components wrap to 16 bits
    function automatic logic [31:0] dft_bin(input tb_frame_t x, input logic [31:0] w [4], input int k);
        longint ar, ai, wr, wi, xr, xm;
        logic [63:0] ar_b, ai_b;
        logic [31:0] t;
        int m;
        ar = 0;
        ai = 0;
        for (int n = 0; n < 8; n++) begin
            m  = (n * k) % 8;
            t  = w[m % 4];
            wr = longint'($signed(t[31:16]));
            wi = longint'($signed(t[15:0]));
            if (m >= 4) begin
                wr = -wr;
                wi = -wi;
            end
            xr = longint'($signed(x[n][31:16]));
            xm = longint'($signed(x[n][15:0]));
            ar += (xr * wr - xm * wi) >>> 11;
            ai += (xr * wi + xm * wr) >>> 11;
        end
        ar_b = ar;
        ai_b = ai;
        return {ar_b[15:0], ai_b[15:0]};
    endfunction

    // fft008 stand-in: input register then output register
    always_ff @(posedge ck) begin
        for (int i = 0; i < 8; i++) xr_q[i] <= xin[i];
        for (int k = 0; k < 8; k++) fo_q[k] <= dft_bin(xr_q, wi_arr, k);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
        cur_n   = 0;
        exp_idx = 0;
    endtask

    // One cycle of traffic: modes 0=low, 1=high, 2=random
    task automatic step(input int sv_mode, input int mr_mode);
        s_valid = (in_q.size() > 0) && (sv_mode == 1 || (sv_mode == 2 && $urandom_range(0, 1) == 1));
        s_data  = s_valid ? in_q[0] : $urandom;
        m_ready = (mr_mode == 1) || (mr_mode == 2 && $urandom_range(0, 1) == 1);
        if (s_valid && s_ready) begin
            cur[cur_n] = in_q.pop_front();
            cur_n++;
            if (cur_n == 8) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(dft_bin(cur, ref_w, k));
                cur_n = 0;
            end
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("bin_unexpected", 32'(m_valid), 32'd0);
            end else begin
                check("bin_data", m_data, exp_q[0]);
                check("bin_idx", 32'(m_idx), 32'(exp_idx));
                check("bin_last", 32'(m_last), 32'(exp_idx == 7));
                void'(exp_q.pop_front());
                exp_idx = (exp_idx + 1) % 8;
                hs_cnt++;
            end
        end
        tick();
    endtask

    // Directed frame with cycle-exact latency and hand-computed bins
    task automatic directed_frame(input tb_frame_t smp, input tb_frame_t want, input int nfr, input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = smp[i];
            check({tag, "_fill_rdy"}, 32'(s_ready), 32'd1);
            tick();
        end
        s_data = 32'hDEAD_BEEF;
        check({tag, "_xi7"}, xi_007, smp[7]);
        check({tag, "_lat0"}, 32'(m_valid), 32'd0);
        check({tag, "_run_rdy"}, 32'(s_ready), 32'd0);
        tick();
        check({tag, "_lat1"}, 32'(m_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(m_valid), 32'd0);
        check({tag, "_stall_rdy"}, 32'(s_ready), 32'd0);
        tick();
        s_valid = 1'b0;
        check({tag, "_lat3"}, 32'(m_valid), 32'd1);
        check({tag, "_frames"}, 32'(frames), 32'(nfr));
        check({tag, "_xi0_held"}, xi_000, smp[0]);
        for (int b = 0; b < 8; b++) begin
            check({tag, "_data"}, m_data, want[b]);
            check({tag, "_idx"}, 32'(m_idx), 32'(b));
            check({tag, "_last"}, 32'(m_last), 32'(b == 7));
            tick();
        end
        check({tag, "_drained"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        tb_frame_t smp;
        tb_frame_t want;
        int n;
        int hs0;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and constant twiddles
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_idx", 32'(m_idx), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
        check("rst_xi0", xi_000, 32'd0);
        check("rst_xi7", xi_007, 32'd0);
        check("wi0", Wi000, 32'h0800_0000);
        check("wi1", Wi001, 32'h05A8_FA58);
        check("wi2", Wi002, 32'h0000_F801);
        check("wi3", Wi003, 32'hFA58_FA58);

        // Constant 1.0 frame: DC bin 8.0, others zero
        for (int i = 0; i < 8; i++) begin
            smp[i]  = 32'h0800_0000;
            want[i] = (i == 0) ? 32'h4000_0000 : 32'h0000_0000;
        end
        directed_frame(smp, want, 1, "dc");

        // Impulse frame: flat spectrum
        for (int i = 0; i < 8; i++) begin
            smp[i]  = (i == 0) ? 32'h0800_0000 : 32'h0000_0000;
            want[i] = 32'h0800_0000;
        end
        directed_frame(smp, want, 2, "imp");

        // Back-to-back frames: s_ready 8 high, 3 low
        for (int i = 0; i < 24; i++) in_q.push_back($urandom);
        for (int c = 0; c < 33; c++) begin
            check("b2b_rdy", 32'(s_ready), 32'((c % 11) < 8));
            step(1, 1);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step(1, 1);
            n++;
        end
        check("b2b_done", 32'(exp_q.size()), 32'd0);
        check("b2b_frames", 32'(frames), 32'd5);

        // Output backpressure holds the second frame in STALL
        for (int i = 0; i < 16; i++) in_q.push_back($urandom);
        for (int c = 0; c < 11; c++) step(1, 0);
        check("bp_cap", 32'(m_valid), 32'd1);
        for (int c = 0; c < 30; c++) step(1, 0);
        check("bp_stall_rdy", 32'(s_ready), 32'd0);
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        check("bp_hold_idx", 32'(m_idx), 32'd0);
        check("bp_frames", 32'(frames), 32'd6);
        hs0 = hs_cnt;
        for (int c = 0; c < 16; c++) step(0, 1);
        check("bp_nobubble", 32'(hs_cnt - hs0), 32'd16);
        check("bp_frames2", 32'(frames), 32'd7);
        check("bp_empty", 32'(m_valid), 32'd0);

        // Random handshakes over 50 frames
        do_reset();
        for (int i = 0; i < 400; i++) in_q.push_back($urandom);
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 8000) begin
            step(2, 2);
            n++;
        end
        check("rnd_in_done", 32'(in_q.size()), 32'd0);
        check("rnd_out_done", 32'(exp_q.size()), 32'd0);
        check("rnd_frames", 32'(frames), 32'd50);

        // Reset while in RUN
        for (int i = 0; i < 8; i++) in_q.push_back($urandom);
        for (int c = 0; c < 8; c++) step(1, 1);
        check("rrun_pre", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        do_reset();
        check("rrun_s_ready", 32'(s_ready), 32'd1);
        check("rrun_m_valid", 32'(m_valid), 32'd0);
        check("rrun_frames", 32'(frames), 32'd0);
        check("rrun_xi0", xi_000, 32'd0);
        check("rrun_xi7", xi_007, 32'd0);

        // Reset mid-drain at bin 4
        for (int i = 0; i < 8; i++) in_q.push_back($urandom);
        for (int c = 0; c < 11; c++) step(1, 0);
        for (int c = 0; c < 4; c++) step(0, 1);
        check("rdrn_pre_idx", 32'(m_idx), 32'd4);
        m_ready = 1'b0;
        do_reset();
        check("rdrn_m_valid", 32'(m_valid), 32'd0);
        check("rdrn_m_idx", 32'(m_idx), 32'd0);
        check("rdrn_m_last", 32'(m_last), 32'd0);
        check("rdrn_frames", 32'(frames), 32'd0);
        check("rdrn_xi3", xi_003, 32'd0);
        check("rdrn_s_ready", 32'(s_ready), 32'd1);

        // Clean frame after reset
        for (int i = 0; i < 8; i++) in_q.push_back($urandom);
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 40) begin
            step(1, 1);
            n++;
        end
        check("post_done", 32'(exp_q.size() + in_q.size()), 32'd0);
        check("post_frames", 32'(frames), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft8_stream_ctrl.md
# fft8_stream_ctrl

Streaming front/back-end controller for the parallel 8-point FFT datapath `fft008`. It collects one complex sample per beat into an 8-entry input frame buffer and holds that frame steady on the `fft008` `xi_*` inputs. It drives the constant twiddles on `Wi*`, waits out the datapath's register latency, and captures the 8 `fo_*` results into an output buffer. It then streams the results out in natural bin order over a valid/ready interface, while the next input frame fills in parallel.

## Interface
Parameters:
- `LAT`, 2: register stages in `fft008` (input reg plus output reg).
- `W0`, 32'h0800_0000: twiddle W^0, {re,im} in Q4.11.
- `W1`, 32'h05A8_FA58: twiddle W^1.
- `W2`, 32'h0000_F801: twiddle W^2.
- `W3`, 32'hFA58_FA58: twiddle W^3.

Ports:
- `ck` in 1: clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: controller accepts a sample this cycle.
- `s_data` in 32: complex sample {re[31:16], im[15:0]}, Q4.11 two's complement.
- `m_valid` out 1: output bin valid.
- `m_ready` in 1: downstream accepts the bin.
- `m_data` out 32: FFT bin {re, im}.
- `m_idx` out 3: bin index 0..7.
- `m_last` out 1: high when `m_idx==7`.
- `xi_000`..`xi_007` out 32 each: frame to `fft008`, straight from the input buffer.
- `Wi000`..`Wi003` out 32 each: constants `W0`..`W3`.
- `fo_000`..`fo_007` in 32 each: results from `fft008`.
- `frames` out 16: count of captured frames, wraps at 2^16.

## Operation
Input FSM states:
- FILL, with write index `wcnt` 0..7:
  - `s_ready=1`.
  - On each `s_valid&&s_ready`, write `ibuf[wcnt]` and increment `wcnt`.
  - On the beat that writes entry 7: go to RUN, clear `rcnt`, reset `wcnt` to 0.
- RUN:
  - `s_ready=0`; `ibuf` is frozen.
  - `rcnt` counts 0..LAT. When `rcnt==LAT`, go to STALL.
- STALL:
  - `s_ready=0`; `fo_*` are valid and stable.
  - On `cap`, write `obuf[k]=fo_k` for all k, increment `frames`, and return to FILL.

Capture condition `cap` = STALL && (!`ovalid` || (`m_valid`&&`m_ready`&&`ridx==7`)):
- Capture is allowed when the output buffer is empty.
- It is also allowed in the same cycle the last bin is consumed, so there is no bubble.

Output side:
- `ovalid` flag and read index `ridx`.
- `m_valid=ovalid`; `m_data=obuf[ridx]`; `m_idx=ridx`.
- Each handshake increments `ridx`. At `ridx==7` it wraps to 0 and clears `ovalid`, unless `cap` fires in the same cycle, in which case `ovalid` stays 1.

Other rules:
- `xi_k=ibuf[k]` at all times.
- The input buffer only changes in FILL, so each frame is held for ≥LAT+1 cycles after its last write.
- No arithmetic in this block; data is passed bit-exact. Only counters increment.
- `s_data` is ignored when `s_ready=0`.

## Timing
- Reset values:
  - State FILL, `wcnt=0`, `rcnt=0`, `ovalid=0`, `ridx=0`, `frames=0`.
  - `ibuf`/`obuf` all zero, so `xi_*=0`.
  - `s_ready=1`, `m_valid=0`, `m_last=0`.
- Reset mid-operation discards any partial input frame, pending capture and undrained bins. The first cycle after `rst` deasserts behaves as post-reset FILL.
- Latency: last input beat at edge E0; capture at edge E0+LAT+1 (E0+3 by default); `m_valid` high from that edge onward.
- Minimum frame period is 8+LAT+1 = 11 cycles when the output drains freely.
- Worst-case output backpressure holds the FSM in STALL indefinitely, with `s_ready=0`.
- Output stability: `m_data`, `m_idx` and `m_last` are stable while `m_valid&&!m_ready`.

## Structure
- Shared package `fft_pkg`:
  - Twiddle constants `W0`..`W3`.
  - Q4.11 complex word width (32) and half width (16).
  - FFT size N=8 and log2N=3.
  - Input FSM state enum {FILL, RUN, STALL}.
- One natural sub-module: `frame_buf8`, an 8×32 register file with indexed write and parallel load/read. Instantiate it twice, as `ibuf` and `obuf`.
- The integration top pairs `fft8_stream_ctrl` with `fft008`; the bench uses that pair.

## Test plan
- Reset, then 8 beats of `s_data=32'h0800_0000` with `m_ready=1`: after 3 cycles the output is bins 0..7 = 32'h4000_0000, then seven 32'h0000_0000. `m_last` is high on bin 7 only, and `frames=1`.
- Impulse frame {32'h0800_0000, then seven zeros}: all 8 bins = 32'h0800_0000. Counting from the last input beat, `m_valid` rises exactly at edge E0+3.
- Back-to-back frames, `s_valid` and `m_ready` held high:
  - `s_ready` pattern is 8 high, 3 low, repeating.
  - Outputs are gap-free, with the capture coinciding with the consumption of bin 7.
- Hold `m_ready=0` for 30 cycles after the first frame completes while a second frame fills: the FSM sits in STALL with `s_ready=0`. When `m_ready` is released, frame 1 drains and then frame 2 follows with no bubble.
- Random `s_valid`/`m_ready` toggling over 50 frames: bins match a reference model bit-exactly and `frames=50`.
- Assert `rst` during the RUN state and again mid-drain at bin 4: all outputs return to their reset values the next cycle, and the following clean frame produces correct results.
